// File: rtl/iodelay_tap_ctrl_pkg.sv
// Shared definitions for the IDELAY tap controller: register word offsets,
// STATUS bit positions, sequencer state encoding and width helpers.
package iodelay_tap_ctrl_pkg;

    // Word offsets, i.e. address bits [7:2]
    localparam logic [5:0] REG_CTRL     = 6'h00;
    localparam logic [5:0] REG_STATUS   = 6'h01;
    localparam logic [5:0] REG_LANE_SEL = 6'h02;
    localparam logic [5:0] REG_TAP      = 6'h03;
    localparam logic [5:0] REG_STEP     = 6'h04;

    localparam int CTRL_VTC_EN = 0;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_RDY    = 1;
    localparam int STAT_ERR    = 2;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_VTC_OFF = 6'b000010,
        ST_ACT     = 6'b000100,
        ST_HOLD    = 6'b001000,
        ST_VTC_ON  = 6'b010000,
        ST_DONE    = 6'b100000
    } seq_state_t;

    function automatic int lane_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The settle counter only has to hold settle_cycles-1
    function automatic int settle_cnt_width(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

endpackage

// File: rtl/iodelay_tap_seq.sv
// VTC-safe tap update sequencer: drops EN_VTC on one lane, settles, pulses
// LOAD or CE, settles again, restores EN_VTC and signals completion.
module iodelay_tap_seq
    import iodelay_tap_ctrl_pkg::*;
#(
    parameter int n_lanes       = 8,
    parameter int settle_cycles = 10,
    parameter int lane_w        = lane_idx_width(n_lanes)
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               start,
    input  logic               simple,
    input  logic               is_load,
    input  logic [lane_w-1:0]  lane,
    input  logic               vtc_en,
    output logic [n_lanes-1:0] en_vtc,
    output logic [n_lanes-1:0] load,
    output logic [n_lanes-1:0] ce,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = settle_cnt_width(settle_cycles);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(settle_cycles - 1);

    seq_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [lane_w-1:0]  lane_reg;
    logic               is_load_reg;
    logic [n_lanes-1:0] lane_mask;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            lane_reg    <= '0;
            is_load_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == ST_IDLE && start) begin
                lane_reg    <= lane;
                is_load_reg <= is_load;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < n_lanes; gi++) begin : g_mask
            assign lane_mask[gi] = (lane_reg == lane_w'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_VTC_OFF;
                    cnt_next   = SETTLE_LAST;
                end else if (simple) begin
                    state_next = ST_DONE;
                end
            end
            ST_VTC_OFF: begin
                if (cnt_reg == '0) state_next = ST_ACT;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            ST_ACT: begin
                state_next = ST_HOLD;
                cnt_next   = SETTLE_LAST;
            end
            ST_HOLD: begin
                if (cnt_reg == '0) state_next = ST_VTC_ON;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            ST_VTC_ON: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // EN_VTC stays low through VTC_ON; the restore takes effect on the edge leaving it
    always_comb begin
        en_vtc = {n_lanes{vtc_en}};
        load   = '0;
        ce     = '0;
        busy   = (state_reg != ST_IDLE);
        done   = (state_reg == ST_DONE);
        if (state_reg inside {ST_VTC_OFF, ST_ACT, ST_HOLD, ST_VTC_ON}) begin
            en_vtc = {n_lanes{vtc_en}} & ~lane_mask;
        end
        if (state_reg == ST_ACT) begin
            if (is_load_reg) load = lane_mask;
            else             ce   = lane_mask;
        end
    end

endmodule

// File: rtl/iodelay_tap_ctrl.sv
// IDELAY tap controller register block: decodes simple-access writes/reads,
// holds CTRL/LANE_SEL/TAP/STEP state and launches the tap update sequencer.
module iodelay_tap_ctrl
    import iodelay_tap_ctrl_pkg::*;
#(
    parameter int acc__addr_width = 64,
    parameter int acc__data_width = 32,
    parameter int n_lanes         = 8,
    parameter int tap_width       = 9,
    parameter int settle_cycles   = 10
) (
    input  logic                         sys__clk,
    input  logic                         sys__srst,
    input  logic [acc__addr_width-1:0]   acc__waddr,
    input  logic [acc__data_width-1:0]   acc__wdata,
    input  logic                         acc__wvalid,
    output logic                         acc__wready,
    input  logic [acc__addr_width-1:0]   acc__raddr,
    output logic [acc__data_width-1:0]   acc__rdata,
    input  logic                         acc__rvalid,
    output logic                         acc__rready,
    output logic [n_lanes-1:0]           dly__en_vtc,
    output logic [n_lanes-1:0]           dly__load,
    output logic [n_lanes-1:0]           dly__ce,
    output logic [n_lanes-1:0]           dly__inc,
    output logic [n_lanes*tap_width-1:0] dly__cntvaluein,
    input  logic [n_lanes*tap_width-1:0] dly__cntvalueout,
    input  logic                         dly__rdy
);

    localparam int LANE_W = lane_idx_width(n_lanes);

    logic                       vtc_en_reg;
    logic                       err_reg;
    logic                       dir_reg;
    logic [7:0]                 lane_sel_reg;
    logic [tap_width-1:0]       tap_reg;
    logic                       rready_reg;
    logic [acc__data_width-1:0] rdata_reg, rdata_next;

    logic [5:0] wr_idx, rd_idx;
    logic       wr_accept, rd_accept;
    logic       is_tap, is_step, lane_ok, seq_ok;
    logic       seq_start, seq_simple, seq_busy, seq_done;
    logic       unused_ok;

    logic [tap_width-1:0] cntout_lane [n_lanes];

    generate
        for (genvar gi = 0; gi < n_lanes; gi++) begin : g_lane
            assign cntout_lane[gi] = dly__cntvalueout[gi*tap_width +: tap_width];
        end
    endgenerate

    // Only address bits [7:2] decode; everything else aliases
    assign unused_ok = ^{acc__waddr, acc__raddr, acc__wdata};

    assign wr_idx     = acc__waddr[7:2];
    assign rd_idx     = acc__raddr[7:2];
    assign wr_accept  = acc__wvalid && !seq_busy;
    assign rd_accept  = acc__rvalid && !rready_reg;
    assign is_tap     = (wr_idx == REG_TAP);
    assign is_step    = (wr_idx == REG_STEP);
    assign lane_ok    = (lane_sel_reg < 8'(n_lanes));
    assign seq_ok     = lane_ok && dly__rdy;
    assign seq_start  = wr_accept && (is_tap || is_step) && seq_ok;
    assign seq_simple = wr_accept && !seq_start;

    always_ff @(posedge sys__clk) begin
        if (sys__srst) begin
            vtc_en_reg   <= 1'b1;
            err_reg      <= 1'b0;
            dir_reg      <= 1'b0;
            lane_sel_reg <= '0;
            tap_reg      <= '0;
            rready_reg   <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            rready_reg <= rd_accept;
            if (rd_accept) rdata_reg <= rdata_next;

            if (wr_accept) begin
                unique case (wr_idx)
                    REG_CTRL:     vtc_en_reg   <= acc__wdata[CTRL_VTC_EN];
                    REG_STATUS:   if (acc__wdata[STAT_ERR]) err_reg <= 1'b0;
                    REG_LANE_SEL: lane_sel_reg <= acc__wdata[7:0];
                    REG_TAP:      tap_reg      <= acc__wdata[tap_width-1:0];
                    REG_STEP:     dir_reg      <= acc__wdata[0];
                    default: ;
                endcase
            end
            // A tap request that cannot be honoured is flagged and dropped
            if (wr_accept && (is_tap || is_step) && !seq_ok) err_reg <= 1'b1;
        end
    end

    always_comb begin
        rdata_next = '0;
        unique case (rd_idx)
            REG_CTRL:     rdata_next[CTRL_VTC_EN] = vtc_en_reg;
            REG_STATUS: begin
                rdata_next[STAT_BUSY] = seq_busy;
                rdata_next[STAT_RDY]  = dly__rdy;
                rdata_next[STAT_ERR]  = err_reg;
            end
            REG_LANE_SEL: rdata_next[7:0] = lane_sel_reg;
            REG_TAP: begin
                if (lane_ok) rdata_next[tap_width-1:0] = cntout_lane[lane_sel_reg[LANE_W-1:0]];
            end
            REG_STEP:     rdata_next[0] = dir_reg;
            default: ;
        endcase
    end

    iodelay_tap_seq #(
        .n_lanes       (n_lanes),
        .settle_cycles (settle_cycles),
        .lane_w        (LANE_W)
    ) u_seq (
        .clk     (sys__clk),
        .srst    (sys__srst),
        .start   (seq_start),
        .simple  (seq_simple),
        .is_load (is_tap),
        .lane    (lane_sel_reg[LANE_W-1:0]),
        .vtc_en  (vtc_en_reg),
        .en_vtc  (dly__en_vtc),
        .load    (dly__load),
        .ce      (dly__ce),
        .busy    (seq_busy),
        .done    (seq_done)
    );

    assign acc__wready     = seq_done;
    assign acc__rready     = rready_reg;
    assign acc__rdata      = rdata_reg;
    assign dly__inc        = {n_lanes{dir_reg}};
    assign dly__cntvaluein = {n_lanes{tap_reg}};

endmodule

// File: tb/tb_iodelay_tap_ctrl.sv
// Self-checking bench for iodelay_tap_ctrl: per-feature tasks, scoreboard
// queues for write completion latency and read data.
module tb_iodelay_tap_ctrl;

    localparam int AW      = 64;
    localparam int N       = 8;
    localparam int TW      = 9;
    localparam int S       = 10;
    localparam int SEQ_LAT = 2*S + 3;

    localparam logic [15:0] A_CTRL   = 16'h0000;
    localparam logic [15:0] A_STATUS = 16'h0004;
    localparam logic [15:0] A_LANE   = 16'h0008;
    localparam logic [15:0] A_TAP    = 16'h000C;
    localparam logic [15:0] A_STEP   = 16'h0010;

    logic          sys__clk = 1'b0;
    logic          sys__srst;
    logic [AW-1:0] acc__waddr, acc__raddr;
    logic [31:0]   acc__wdata, acc__rdata;
    logic          acc__wvalid, acc__wready, acc__rvalid, acc__rready;
    logic [N-1:0]  dly__en_vtc, dly__load, dly__ce, dly__inc;
    logic [N*TW-1:0] dly__cntvaluein, dly__cntvalueout;
    logic          dly__rdy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int          wr_q[$];
    logic [31:0] rd_q[$];

    logic [TW-1:0] tap_model;
    logic          dir_model;
    logic          vtc_model;

    iodelay_tap_ctrl #(
        .acc__addr_width (AW),
        .acc__data_width (32),
        .n_lanes         (N),
        .tap_width       (TW),
        .settle_cycles   (S)
    ) dut (
        .sys__clk         (sys__clk),
        .sys__srst        (sys__srst),
        .acc__waddr       (acc__waddr),
        .acc__wdata       (acc__wdata),
        .acc__wvalid      (acc__wvalid),
        .acc__wready      (acc__wready),
        .acc__raddr       (acc__raddr),
        .acc__rdata       (acc__rdata),
        .acc__rvalid      (acc__rvalid),
        .acc__rready      (acc__rready),
        .dly__en_vtc      (dly__en_vtc),
        .dly__load        (dly__load),
        .dly__ce          (dly__ce),
        .dly__inc         (dly__inc),
        .dly__cntvaluein  (dly__cntvaluein),
        .dly__cntvalueout (dly__cntvalueout),
        .dly__rdy         (dly__rdy)
    );

    always #5 sys__clk = ~sys__clk;
    always @(posedge sys__clk) cyc <= cyc + 1;

    // Write with per-cycle checks of the delay pins; seq=1 expects a full tap sequence on mask
    task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                            input bit seq, input logic [N-1:0] mask, input string name);
        int t0, n, lat;
        bit seen, is_tap;
        int bad_en, bad_act, bad_cv, bad_inc;
        logic [N-1:0] exp_en, exp_load, exp_ce;
        is_tap = (addr == A_TAP);
        seen = 0; bad_en = 0; bad_act = 0; bad_cv = 0; bad_inc = 0;
        wr_q.push_back(seq ? SEQ_LAT : 1);
        acc__waddr  = {{(AW-16){1'b0}}, addr};
        acc__wdata  = data;
        acc__wvalid = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge sys__clk);
            n = cyc - t0;
            exp_en = {N{vtc_model}};
            if (seq && n >= 1 && n <= 2*S+2) exp_en = exp_en & ~mask;
            exp_load = (seq && is_tap && n == S+1) ? mask : '0;
            exp_ce   = (seq && !is_tap && n == S+1) ? mask : '0;
            if (addr != A_CTRL && dly__en_vtc !== exp_en) begin
                if (bad_en == 0) $display("FAIL %s en_vtc cycle t+%0d: got %h expected %h", name, n, dly__en_vtc, exp_en);
                bad_en++;
            end
            if (dly__load !== exp_load || dly__ce !== exp_ce) begin
                if (bad_act == 0) $display("FAIL %s load/ce cycle t+%0d: got %h/%h expected %h/%h",
                                           name, n, dly__load, dly__ce, exp_load, exp_ce);
                bad_act++;
            end
            if (seq && is_tap && dly__cntvaluein !== {N{tap_model}}) begin
                if (bad_cv == 0) $display("FAIL %s cntvaluein cycle t+%0d: got %h expected %h", name, n, dly__cntvaluein, {N{tap_model}});
                bad_cv++;
            end
            if (seq && !is_tap && dly__inc !== {N{dir_model}}) begin
                if (bad_inc == 0) $display("FAIL %s inc cycle t+%0d: got %h expected %h", name, n, dly__inc, {N{dir_model}});
                bad_inc++;
            end
            if (acc__wready === 1'b1) begin
                seen = 1;
                lat = wr_q.pop_front();
                checks++;
                if (n != lat) begin
                    errors++;
                    $display("FAIL %s wready latency: got t+%0d expected t+%0d", name, n, lat);
                end
            end
        end
        acc__wvalid = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s wready timeout: got none expected t+%0d", name, wr_q.pop_front());
        end
        if (addr != A_CTRL) begin checks++; if (bad_en != 0) errors++; end
        checks++; if (bad_act != 0) errors++;
        if (seq && is_tap)  begin checks++; if (bad_cv != 0) errors++; end
        if (seq && !is_tap) begin checks++; if (bad_inc != 0) errors++; end
        @(negedge sys__clk);
        checks++;
        if (acc__wready !== 1'b0) begin
            errors++;
            $display("FAIL %s wready pulse width: got %b after pulse expected 0", name, acc__wready);
        end
        $display("write %s addr=%h data=%h done", name, addr, data);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [31:0] exp, input string name);
        int t0;
        bit seen;
        logic [31:0] e;
        seen = 0;
        rd_q.push_back(exp);
        acc__raddr  = {{(AW-16){1'b0}}, addr};
        acc__rvalid = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge sys__clk);
            if (acc__rready === 1'b1) begin
                seen = 1;
                e = rd_q.pop_front();
                checks += 2;
                if (cyc - t0 != 1) begin
                    errors++;
                    $display("FAIL %s rready latency: got t+%0d expected t+1", name, cyc - t0);
                end
                if (acc__rdata !== e) begin
                    errors++;
                    $display("FAIL %s rdata: got %h expected %h", name, acc__rdata, e);
                end
            end
        end
        acc__rvalid = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s rready timeout: got none expected %h", name, rd_q.pop_front());
        end
        @(negedge sys__clk);
        $display("read %s addr=%h data=%h expected=%h", name, addr, acc__rdata, exp);
    endtask

    task automatic test_reset();
        sys__srst = 1'b1;
        repeat (3) @(negedge sys__clk);
        checks++;
        if (dly__en_vtc !== 8'hFF || dly__load !== 8'h00 || dly__ce !== 8'h00 || dly__inc !== 8'h00 ||
            dly__cntvaluein !== '0 || acc__wready !== 1'b0 || acc__rready !== 1'b0 || acc__rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%h load=%h ce=%h inc=%h cv=%h wr=%b rr=%b rd=%h expected en=ff rest 0",
                     dly__en_vtc, dly__load, dly__ce, dly__inc, dly__cntvaluein, acc__wready, acc__rready, acc__rdata);
        end
        sys__srst = 1'b0;
        @(negedge sys__clk);
        vtc_model = 1'b1; tap_model = '0; dir_model = 1'b0;
        do_read(A_STATUS, 32'h2, "reset_status");
        do_read(A_LANE,   32'h0, "reset_lane_sel");
        do_read(A_CTRL,   32'h1, "reset_ctrl");
    endtask

    task automatic test_tap_load();
        do_write(A_LANE, 32'h3, 1'b0, '0, "lane_sel_3");
        tap_model = 9'h05A;
        do_write(A_TAP, 32'h05A, 1'b1, 8'h08, "tap_lane3");
        do_read(A_LANE, 32'h3, "lane_sel_rb");
    endtask

    task automatic test_step();
        do_write(A_LANE, 32'h0, 1'b0, '0, "lane_sel_0");
        dir_model = 1'b1;
        do_write(A_STEP, 32'h1, 1'b1, 8'h01, "step_inc");
        do_read(A_STEP, 32'h1, "step_dir_inc");
        dir_model = 1'b0;
        do_write(A_STEP, 32'h0, 1'b1, 8'h01, "step_dec");
        do_read(A_STEP, 32'h0, "step_dir_dec");
    endtask

    task automatic test_errors();
        do_write(A_LANE, 32'h9, 1'b0, '0, "lane_sel_9");
        do_write(A_TAP, 32'h033, 1'b0, '0, "tap_bad_lane");
        do_read(A_STATUS, 32'h6, "status_err");
        do_read(A_TAP, 32'h0, "tap_read_oob");
        do_write(A_STATUS, 32'h4, 1'b0, '0, "err_clear");
        do_read(A_STATUS, 32'h2, "status_cleared");
        do_write(A_LANE, 32'h0, 1'b0, '0, "lane_sel_0b");
        dly__rdy = 1'b0;
        do_write(A_STEP, 32'h1, 1'b0, '0, "step_not_rdy");
        do_read(A_STATUS, 32'h4, "status_not_rdy");
        dly__rdy = 1'b1;
        do_write(A_STATUS, 32'h4, 1'b0, '0, "err_clear2");
        do_read(A_STATUS, 32'h2, "status_cleared2");
        do_read(16'h0040, 32'h0, "unmapped");
        do_read(16'h0109, 32'h0, "alias_lane_sel");
    endtask

    task automatic test_read_during_seq();
        dly__cntvalueout = '0;
        dly__cntvalueout[2*TW +: TW] = 9'h1C3;
        dly__cntvalueout[5*TW +: TW] = 9'h0F0;
        do_write(A_LANE, 32'h2, 1'b0, '0, "lane_sel_2");
        tap_model = 9'h100;
        fork
            do_write(A_TAP, 32'h100, 1'b1, 8'h04, "tap_lane2");
            begin
                repeat (4) @(negedge sys__clk);
                do_read(A_STATUS, 32'h3, "status_busy");
                do_read(A_TAP, 32'h1C3, "tap_read_lane2");
            end
        join
        do_read(A_STATUS, 32'h2, "status_idle");
    endtask

    task automatic test_back_to_back();
        vtc_model = 1'b0;
        do_write(A_CTRL, 32'h0, 1'b0, '0, "ctrl_off");
        checks++;
        if (dly__en_vtc !== 8'h00) begin
            errors++;
            $display("FAIL vtc_off_idle: got %h expected 00", dly__en_vtc);
        end
        do_read(A_CTRL, 32'h0, "ctrl_rb0");
        do_write(A_LANE, 32'h7, 1'b0, '0, "lane_sel_7");
        dir_model = 1'b1;
        do_write(A_STEP, 32'h1, 1'b1, 8'h80, "step_lane7_vtc0");
        vtc_model = 1'b1;
        do_write(A_CTRL, 32'h1, 1'b0, '0, "ctrl_on");
        checks++;
        if (dly__en_vtc !== 8'hFF) begin
            errors++;
            $display("FAIL vtc_on_idle: got %h expected ff", dly__en_vtc);
        end
    endtask

    task automatic test_reset_mid_seq();
        int t0;
        do_write(A_LANE, 32'h1, 1'b0, '0, "lane_sel_1");
        acc__waddr  = {{(AW-16){1'b0}}, A_TAP};
        acc__wdata  = 32'h0AA;
        acc__wvalid = 1'b1;
        t0 = cyc;
        while (cyc - t0 < S + 2) @(negedge sys__clk);
        checks++;
        if (dly__en_vtc !== 8'hFD) begin
            errors++;
            $display("FAIL mid_seq_hold en_vtc: got %h expected fd", dly__en_vtc);
        end
        sys__srst = 1'b1;
        @(negedge sys__clk);
        sys__srst   = 1'b0;
        acc__wvalid = 1'b0;
        checks++;
        if (dly__en_vtc !== 8'hFF || acc__wready !== 1'b0 || dly__load !== 8'h00 ||
            dly__ce !== 8'h00 || dly__cntvaluein !== '0) begin
            errors++;
            $display("FAIL reset_mid_seq: got en=%h wr=%b load=%h ce=%h cv=%h expected en=ff rest 0",
                     dly__en_vtc, acc__wready, dly__load, dly__ce, dly__cntvaluein);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge sys__clk);
            checks++;
            if (acc__wready !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_wready: got %b expected 0", acc__wready);
            end
        end
        vtc_model = 1'b1; tap_model = '0; dir_model = 1'b0;
        do_read(A_STATUS, 32'h2, "status_after_reset");
        tap_model = 9'h011;
        do_write(A_TAP, 32'h011, 1'b1, 8'h01, "tap_after_reset");
    endtask

    initial begin
        sys__srst        = 1'b1;
        acc__waddr       = '0;
        acc__wdata       = '0;
        acc__wvalid      = 1'b0;
        acc__raddr       = '0;
        acc__rvalid      = 1'b0;
        dly__cntvalueout = '0;
        dly__rdy         = 1'b1;
        vtc_model        = 1'b1;
        tap_model        = '0;
        dir_model        = 1'b0;
        @(negedge sys__clk);
        test_reset();
        test_tap_load();
        test_step();
        test_errors();
        test_read_during_seq();
        test_back_to_back();
        test_reset_mid_seq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
